mem_port_arbiter: RTL

Two-requester arbiter that shares the single off-chip memory port between the instruction cache (port 0) and the data cache (port 1). It owns the mem_* interface toward Data_Memory and presents each cache with an identical enable/ack interface. Arbitration is round-robin, with one transaction outstanding at a time and a watchdog timeout. It sits between the cache controllers and the top-level mem_* ports.

---
 rtl/mem_port_arbiter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing one memory port between icache (p0) and dcache (p1)
module mem_port_arbiter #(
    parameter int DATA_W  = 256,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              p0_enable_i,
    input  logic              p0_write_i,
    input  logic [ADDR_W-1:0] p0_addr_i,
    input  logic [DATA_W-1:0] p0_data_i,
    output logic [DATA_W-1:0] p0_data_o,
    output logic              p0_ack_o,

    input  logic              p1_enable_i,
    input  logic              p1_write_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [DATA_W-1:0] p1_data_i,
    output logic [DATA_W-1:0] p1_data_o,
    output logic              p1_ack_o,

    input  logic [DATA_W-1:0] mem_data_i,
    input  logic              mem_ack_i,
    output logic [DATA_W-1:0] mem_data_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,

    output logic              busy_o,
    output logic              timeout_o
);

    localparam int WDOG_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WDOG_W-1:0] WDOG_LAST = (TIMEOUT > 0) ? WDOG_W'(TIMEOUT - 1) : '0;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic               owner_q, owner_d;
    logic               last_grant_q, last_grant_d;
    logic [WDOG_W-1:0]  wdog_q, wdog_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               enable_q, enable_d;
    logic               write_q, write_d;
    logic               timeout_q, timeout_d;
    logic               winner;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b0;
            wdog_q       <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            enable_q     <= 1'b0;
            write_q      <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            wdog_q       <= wdog_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            enable_q     <= enable_d;
            write_q      <= write_d;
            timeout_q    <= timeout_d;
        end
    end

    // On a tie the port that did not win last time is served; otherwise the lone requester.
    always_comb begin
        if (p0_enable_i && p1_enable_i) begin
            winner = ~last_grant_q;
        end else begin
            winner = p1_enable_i;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        wdog_d       = wdog_q;
        addr_d       = addr_q;
        data_d       = data_q;
        enable_d     = enable_q;
        write_d      = write_q;
        timeout_d    = timeout_q;

        case (state_q)
            S_IDLE: begin
                if (p0_enable_i || p1_enable_i) begin
                    state_d      = S_BUSY;
                    owner_d      = winner;
                    last_grant_d = winner;
                    wdog_d       = '0;
                    addr_d       = winner ? p1_addr_i  : p0_addr_i;
                    data_d       = winner ? p1_data_i  : p0_data_i;
                    write_d      = winner ? p1_write_i : p0_write_i;
                    enable_d     = 1'b1;
                end
            end
            S_BUSY: begin
                // A completion arriving on the watchdog's last cycle still counts as success.
                if (mem_ack_i) begin
                    state_d  = S_IDLE;
                    enable_d = 1'b0;
                    write_d  = 1'b0;
                    wdog_d   = '0;
                end else if ((TIMEOUT != 0) && (wdog_q == WDOG_LAST)) begin
                    state_d   = S_IDLE;
                    enable_d  = 1'b0;
                    write_d   = 1'b0;
                    wdog_d    = '0;
                    timeout_d = 1'b1;
                end else begin
                    wdog_d = wdog_q + WDOG_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign p0_ack_o     = mem_ack_i & (state_q == S_BUSY) & ~owner_q;
    assign p1_ack_o     = mem_ack_i & (state_q == S_BUSY) &  owner_q;
    assign p0_data_o    = mem_data_i;
    assign p1_data_o    = mem_data_i;

    assign mem_addr_o   = addr_q;
    assign mem_data_o   = data_q;
    assign mem_enable_o = enable_q;
    assign mem_write_o  = write_q;
    assign busy_o       = (state_q == S_BUSY);
    assign timeout_o    = timeout_q;

endmodule
